snail_pattern_tx: RTL

//  Serial stimulus transmitter for the snail "01" edge detector: accepts a pattern word

---
 rtl/snail_pkg.sv | 5 +
 rtl/snail_pattern_tx_if.sv | 12 +
 rtl/snail_edge_counter.sv | 20 ++
 rtl/snail_pattern_tx.sv | 75 +++++++
 4 files changed

// File: rtl/snail_pkg.sv
// snail_pkg: shared FSM state type and idle line level for the snail pattern transmitter
package snail_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic IDLE_LVL = 1'b0;
endpackage

// File: rtl/snail_pattern_tx_if.sv
// snail_pattern_tx_if: valid/ready pattern word handshake
interface snail_pattern_tx_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  modport master(output valid, data, len, input ready);
  modport slave(input valid, data, len, output ready);
endinterface

// File: rtl/snail_edge_counter.sv
// snail_edge_counter: saturating count of 0->1 transitions on a serial line
module snail_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic prev;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= line;
      cnt <= clr ? '0 : (line && !prev && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
    end
endmodule

// File: rtl/snail_pattern_tx.sv
// snail_pattern_tx: serialises a pattern word MSB-first onto a and counts the smiles it emits
module snail_pattern_tx
  import snail_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  snail_pattern_tx_if.slave   word,
  input  logic                cnt_clr,
  output logic                a,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    smile_cnt
);
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] aligned;
  assign len_c = (word.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : word.len;
  // left-justify the selected window so the first bit sits at the MSB
  assign aligned = word.data << (LEN_W'(WIDTH) - len_c);
  assign word.ready = (state == IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      a <= IDLE_LVL;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (word.valid) begin
            if (len_c == '0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= SHIFT;
              busy <= 1'b1;
              a <= aligned[WIDTH-1];
              sr <= aligned << 1;
              cnt <= len_c - LEN_W'(1);
            end
          end
        SHIFT:
          if (cnt == '0) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            a <= IDLE_LVL;
          end else begin
            a <= sr[WIDTH-1];
            sr <= sr << 1;
            cnt <= cnt - LEN_W'(1);
          end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  snail_edge_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .line (a),
    .clr  (cnt_clr),
    .cnt  (smile_cnt)
  );
endmodule
